nbyn_router_buf: RTL
====================

// Module: nbyn_router_buf
// PURPOSE
//  Buffered, parametrised successor to the unbuffered mesh tile switch.
//  - Inputs: left (L), bottom (B) and local PE. Outputs: right (R), top (T) and local PE.
//  - Each input has a FIFO. Each output has a round-robin arbiter and a one-stage output register.
//  - Sits at every (X_COORD,Y_COORD) node of the unidirectional NxN torus, between neighbour tiles and the PE.
// PARAMETERS
//  X_COORD     0   this node's x coordinate
//  Y_COORD     0   this node's y coordinate
//  X_W         4   width of the x destination field
//  Y_W         4   width of the y destination field
//  DATA_W      32  payload width
//  FIFO_DEPTH  4   entries per input FIFO; power of two, >=2
//  FLIT_W      DATA_W+Y_W+X_W (derived, localparam). Flit layout = {payload, y_dest, x_dest}; x_dest in LSBs.
// PORTS
//  clk                in   1       single clock, rising edge
//  rst                in   1       asynchronous, active-high reset
//  i_valid_l/b/pe     in   1       flit valid from left / bottom / PE
//  o_ready_l/b/pe     out  1       this node can accept a flit on that input
//  i_data_l/b/pe      in   FLIT_W  input flits
//  o_valid_r/t/pe     out  1       flit valid toward right / top / PE
//  i_ready_r/t/pe     in   1       downstream accepts
//  o_data_r/t/pe      out  FLIT_W  output flits
// BEHAVIOUR
//  - Reset (async assert, sync-clean deassert): all FIFOs empty; output registers invalid.
//    o_valid_* = 0, o_data_* = 0, arbiter pointers = L, o_ready_* = 1 in the first cycle after reset.
//  - Handshake: a transfer occurs on a rising edge where valid && ready.
//    o_ready_x = !full_x and is registered (no combinational path from i_ready_*).
//    o_valid/o_data hold stable until accepted.
//  - Routing of each FIFO head:
//    x_dest != X_COORD -> R; else y_dest != Y_COORD -> T; else -> PE.
//    Wrap-around is implicit in the torus; no coordinate arithmetic.
//  - Allowed request paths: L may request R, T or PE. B may request T or PE. PE may request R, T or PE.
//    Loopback PE->PE is legal.
//  - Output stage: the output register loads when (!o_valid || i_ready) && a winner exists.
//    Full throughput: one flit per output per cycle.
//  - Arbitration: per-output round-robin over requesting inputs, order L->B->PE.
//    The pointer advances to the input after the winner only when a flit is transferred.
//    Each input pops at most one flit per cycle. Because routing is deterministic, one head targets exactly one output.
//  - Latency: flit accepted at edge N is at its FIFO head after N. On an idle path o_valid rises after edge N+1.
//  - FIFO: write when i_valid&&o_ready; read when its head wins. Read and write in the same cycle are both honoured, count unchanged.
//    Full: o_ready=0, no write. Empty: no request.
//    Pointers are log2(FIFO_DEPTH) bits and wrap naturally; count is log2(FIFO_DEPTH)+1 bits.
//  - Back-pressure: a stalled output stalls only the FIFOs whose heads target it. Other outputs keep flowing.
//  - Reset mid-operation discards all in-flight flits immediately. No partial flit is emitted.
//  - Payload is never modified.
// STRUCTURE
//  - Package nbyn_pkg: port index constants (P_L=0, P_B=1, P_PE=2), direction enum {DIR_R, DIR_T, DIR_PE}, FLIT_W computation helper.
//  - Sub-module nbyn_fifo #(WIDTH, DEPTH), instantiated 3 times.
//  - Routing, arbiters and output registers are inline. Three identical arbiters may use a generate loop.
// TESTING
//  1 Reset: assert rst mid-traffic with FIFOs holding 3 flits
//    -> next cycle all o_valid=0, o_ready=1, no stale flit after release.
//  2 Routing at X_COORD=1, Y_COORD=1:
//    L sends x=2 -> exits R.
//    B sends x=1,y=3 -> exits T.
//    PE sends x=1,y=1 -> exits PE with data unchanged.
//    Each appears one cycle after acceptance.
//  3 Contention: L, B and PE all target T every cycle, i_ready_t=1
//    -> grants L,B,PE,L,B,PE... with T throughput 1 flit/cycle.
//  4 Back-pressure: i_ready_r=0 with FIFO_DEPTH=4
//    -> L accepts 5 flits (4 in FIFO + 1 in output register), then o_ready_l=0.
//    Releasing i_ready_r drains the flits in order.
//  5 Independence: while R is stalled, B->T traffic keeps flowing at 1 flit/cycle.
//  6 FIFO wrap: stream 20 flits through L->PE with random i_ready_pe
//    -> all 20 delivered in order, none lost or duplicated.

Source files
------------

// File: rtl/nbyn_pkg.sv
// Shared constants and types for the buffered mesh tile router.
// Input port indices, output direction encoding and flit width helper.
package nbyn_pkg;

  localparam int NPORT = 3;
  localparam int P_L   = 0;
  localparam int P_B   = 1;
  localparam int P_PE  = 2;

  typedef enum logic [1:0] {
    DIR_R  = 2'd0,
    DIR_T  = 2'd1,
    DIR_PE = 2'd2
  } dir_e;

  function automatic int flit_w(input int data_w, input int y_w, input int x_w);
    return data_w + y_w + x_w;
  endfunction

endpackage

// File: rtl/nbyn_fifo.sv
// Small synchronous FIFO with combinational head read and registered status flags.
module nbyn_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_en_i,
  input  logic [WIDTH-1:0] wr_data_i,
  input  logic             rd_en_i,
  output logic [WIDTH-1:0] rd_data_o,
  output logic             empty_o,
  output logic             full_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             wr, rd;

  assign empty_o   = (count_q == '0);
  assign full_o    = (count_q == (AW+1)'(DEPTH));
  assign wr        = wr_en_i && !full_o;
  assign rd        = rd_en_i && !empty_o;
  assign rd_data_o = mem_q[rd_ptr_q];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (wr) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (rd) rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({wr, rd})
        2'b10:   count_q <= count_q + (AW+1)'(1);
        2'b01:   count_q <= count_q - (AW+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset; the pointers alone define what is valid.
  always_ff @(posedge clk) begin
    if (wr) mem_q[wr_ptr_q] <= wr_data_i;
  end

endmodule

// File: rtl/nbyn_router_buf.sv
// Buffered torus tile switch: per-input FIFOs, per-output round-robin arbiters
// and one-stage output registers between neighbour tiles and the local PE.
module nbyn_router_buf
  import nbyn_pkg::*;
#(
  parameter  int X_COORD    = 0,
  parameter  int Y_COORD    = 0,
  parameter  int X_W        = 4,
  parameter  int Y_W        = 4,
  parameter  int DATA_W     = 32,
  parameter  int FIFO_DEPTH = 4,
  localparam int FLIT_W     = flit_w(DATA_W, Y_W, X_W)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_valid_l,
  input  logic              i_valid_b,
  input  logic              i_valid_pe,
  output logic              o_ready_l,
  output logic              o_ready_b,
  output logic              o_ready_pe,
  input  logic [FLIT_W-1:0] i_data_l,
  input  logic [FLIT_W-1:0] i_data_b,
  input  logic [FLIT_W-1:0] i_data_pe,
  output logic              o_valid_r,
  output logic              o_valid_t,
  output logic              o_valid_pe,
  input  logic              i_ready_r,
  input  logic              i_ready_t,
  input  logic              i_ready_pe,
  output logic [FLIT_W-1:0] o_data_r,
  output logic [FLIT_W-1:0] o_data_t,
  output logic [FLIT_W-1:0] o_data_pe
);

  logic [NPORT-1:0]              in_valid, push, pop, fifo_empty, fifo_full;
  logic [NPORT-1:0][FLIT_W-1:0]  in_data, head;
  dir_e                          route [NPORT];
  logic [NPORT-1:0][NPORT-1:0]   req, gnt;
  logic [NPORT-1:0]              load, out_ready;
  logic [NPORT-1:0]              out_valid_q, out_valid_d;
  logic [NPORT-1:0][FLIT_W-1:0]  out_data_q, out_data_d;
  logic [NPORT-1:0][1:0]         ptr_q, ptr_d;

  assign in_valid       = {i_valid_pe, i_valid_b, i_valid_l};
  assign in_data[P_L]   = i_data_l;
  assign in_data[P_B]   = i_data_b;
  assign in_data[P_PE]  = i_data_pe;
  assign out_ready      = {i_ready_pe, i_ready_t, i_ready_r};
  assign push           = in_valid & ~fifo_full;

  // Ready comes straight from the FIFO count register, never from i_ready_*.
  assign o_ready_l  = ~fifo_full[P_L];
  assign o_ready_b  = ~fifo_full[P_B];
  assign o_ready_pe = ~fifo_full[P_PE];

  for (genvar g = 0; g < NPORT; g++) begin : g_fifo
    nbyn_fifo #(
      .WIDTH(FLIT_W),
      .DEPTH(FIFO_DEPTH)
    ) u_fifo (
      .clk      (clk),
      .rst      (rst),
      .wr_en_i  (push[g]),
      .wr_data_i(in_data[g]),
      .rd_en_i  (pop[g]),
      .rd_data_o(head[g]),
      .empty_o  (fifo_empty[g]),
      .full_o   (fifo_full[g])
    );
  end

  function automatic logic [NPORT-1:0] rr_pick(input logic [NPORT-1:0] r,
                                               input logic [1:0]       ptr);
    logic [NPORT-1:0] g;
    logic [2:0]       idx;
    g = '0;
    // Scan from lowest to highest priority so the highest-priority requester wins last.
    for (int k = NPORT - 1; k >= 0; k--) begin
      idx = {1'b0, ptr} + 3'(k);
      if (idx >= 3'(NPORT)) idx = idx - 3'(NPORT);
      if (r[idx[1:0]]) g = NPORT'(1) << idx[1:0];
    end
    return g;
  endfunction

  function automatic logic [1:0] rr_next(input logic [NPORT-1:0] g);
    if (g[P_L]) return 2'd1;
    if (g[P_B]) return 2'd2;
    return 2'd0;
  endfunction

  // Dimension-order routing; B arrives already aligned in x, so only y decides.
  always_comb begin
    for (int i = 0; i < NPORT; i++) begin
      if ((i != P_B) && (head[i][X_W-1:0] != X_W'(X_COORD)))
        route[i] = DIR_R;
      else if (head[i][X_W +: Y_W] != Y_W'(Y_COORD))
        route[i] = DIR_T;
      else
        route[i] = DIR_PE;
    end
  end

  always_comb begin
    req         = '0;
    gnt         = '0;
    load        = '0;
    pop         = '0;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    ptr_d       = ptr_q;
    for (int o = 0; o < NPORT; o++) begin
      for (int i = 0; i < NPORT; i++)
        req[o][i] = !fifo_empty[i] && (route[i] == dir_e'(2'(o)));
      gnt[o]  = rr_pick(req[o], ptr_q[o]);
      load[o] = (!out_valid_q[o] || out_ready[o]) && (|req[o]);
      if (out_ready[o]) out_valid_d[o] = 1'b0;
      if (load[o]) begin
        out_valid_d[o] = 1'b1;
        ptr_d[o]       = rr_next(gnt[o]);
        pop            = pop | gnt[o];
        for (int i = 0; i < NPORT; i++)
          if (gnt[o][i]) out_data_d[o] = head[i];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q <= '0;
      out_data_q  <= '0;
      ptr_q       <= '0;
    end else begin
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      ptr_q       <= ptr_d;
    end
  end

  assign o_valid_r  = out_valid_q[DIR_R];
  assign o_valid_t  = out_valid_q[DIR_T];
  assign o_valid_pe = out_valid_q[DIR_PE];
  assign o_data_r   = out_data_q[DIR_R];
  assign o_data_t   = out_data_q[DIR_T];
  assign o_data_pe  = out_data_q[DIR_PE];

endmodule
